// File: rtl/gemmini_pkg.sv
// Shared widths and the per-column PE control bundle for the mesh front end.
package gemmini_pkg;

    localparam int A_W  = 8;
    localparam int BD_W = 20;
    localparam int ID_W = 3;
    localparam int SH_W = 5;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            last;
        logic            dataflow;
        logic            propagate;
        logic [SH_W-1:0] shift;
    } pe_ctrl_t;

    localparam int CTRL_W = $bits(pe_ctrl_t);

endpackage

// File: rtl/mesh_input_skew_lane.sv
// Valid+payload shift chain of fixed depth; payload is forced to zero on bubbles.
module skew_lane #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [DEPTH-1:0]        valid_q;
    logic [DEPTH-1:0][W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_valid ? in_data : '0;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/mesh_input_skew.sv
// Staggers each accepted row so lane i reaches the mesh i+1 cycles later,
// and holds off the next tile until the last row has fully left the chains.
module mesh_input_skew #(
    parameter int DIM  = 4,
    parameter int A_W  = gemmini_pkg::A_W,
    parameter int BD_W = gemmini_pkg::BD_W,
    parameter int ID_W = gemmini_pkg::ID_W,
    parameter int SH_W = gemmini_pkg::SH_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DIM*A_W-1:0]  in_a,
    input  logic [DIM*BD_W-1:0] in_b,
    input  logic [DIM*BD_W-1:0] in_d,
    input  logic [ID_W-1:0]     in_id,
    input  logic                in_last,
    input  logic                in_dataflow,
    input  logic                in_propagate,
    input  logic [SH_W-1:0]     in_shift,
    output logic [DIM-1:0]      out_a_valid,
    output logic [DIM*A_W-1:0]  out_a,
    output logic [DIM-1:0]      out_bd_valid,
    output logic [DIM*BD_W-1:0] out_b,
    output logic [DIM*BD_W-1:0] out_d,
    output logic [DIM*ID_W-1:0] out_id,
    output logic [DIM-1:0]      out_last,
    output logic [DIM-1:0]      out_dataflow,
    output logic [DIM-1:0]      out_propagate,
    output logic [DIM*SH_W-1:0] out_shift,
    output logic                drained
);

    import gemmini_pkg::*;

    localparam int   CNT_W    = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int   BD_LW    = 2*BD_W + CTRL_W;
    localparam logic ONE_LANE = (DIM == 1);

    logic [CNT_W-1:0] drain_cnt;
    logic             drained_q;
    logic             fire;
    pe_ctrl_t         in_ctrl;

    assign in_ready = (drain_cnt == '0);
    assign fire     = in_valid && in_ready;
    assign drained  = drained_q;

    assign in_ctrl = '{id: in_id, last: in_last, dataflow: in_dataflow,
                       propagate: in_propagate, shift: in_shift};

    // drained lines up with the last row's final lane leaving column DIM-1
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt <= '0;
            drained_q <= 1'b0;
        end else begin
            drained_q <= (drain_cnt == CNT_W'(1)) || (fire && in_last && ONE_LANE);
            if (fire && in_last)
                drain_cnt <= CNT_W'(DIM - 1);
            else if (drain_cnt != '0)
                drain_cnt <= drain_cnt - CNT_W'(1);
        end
    end

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        logic [BD_LW-1:0] bd_out;
        pe_ctrl_t         lane_ctrl;

        skew_lane #(.W(A_W), .DEPTH(i+1)) u_a (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (fire),
            .in_data   (in_a[i*A_W +: A_W]),
            .out_valid (out_a_valid[i]),
            .out_data  (out_a[i*A_W +: A_W])
        );

        skew_lane #(.W(BD_LW), .DEPTH(i+1)) u_bd (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (fire),
            .in_data   ({in_b[i*BD_W +: BD_W], in_d[i*BD_W +: BD_W], in_ctrl}),
            .out_valid (out_bd_valid[i]),
            .out_data  (bd_out)
        );

        assign lane_ctrl                  = bd_out[CTRL_W-1:0];
        assign out_b[i*BD_W +: BD_W]      = bd_out[CTRL_W+BD_W +: BD_W];
        assign out_d[i*BD_W +: BD_W]      = bd_out[CTRL_W +: BD_W];
        assign out_id[i*ID_W +: ID_W]     = lane_ctrl.id;
        assign out_last[i]                = lane_ctrl.last;
        assign out_dataflow[i]            = lane_ctrl.dataflow;
        assign out_propagate[i]           = lane_ctrl.propagate;
        assign out_shift[i*SH_W +: SH_W]  = lane_ctrl.shift;
    end

endmodule
